// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: mode encodings, colour-bar table and width helper shared by the VGA pattern block.
package vga_timing_pkg;
  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_GRAD  = 2'd3
  } mode_e;
  // {R,G,B} on/off flags; entry 0 is the leftmost bar (white .. black)
  localparam logic [7:0][2:0] BAR_LUT = {3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111};
  function automatic int clog2w(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/vga_sync_counter.sv
// vga_sync_counter: h/v raster counters with region decode and raw active/sync/frame-start flags.
// Counters hold at (0,0) for one cycle after reset so the first frame starts on a clean edge.
module vga_sync_counter
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW = clog2w(H_TOTAL),
  localparam int VW = clog2w(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  output logic [HW-1:0] h_o,
  output logic [VW-1:0] v_o,
  output logic          run_o,
  output logic          h_last_o,
  output logic          active_o,
  output logic          hs_o,
  output logic          vs_o,
  output logic          origin_o
);
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic run_q, v_last;
  always_comb begin
    h_last_o = h_q == HW'(H_TOTAL - 1);
    v_last = v_q == VW'(V_TOTAL - 1);
    h_d = !run_q ? h_q : h_last_o ? '0 : h_q + 1'b1;
    v_d = !run_q || !h_last_o ? v_q : v_last ? '0 : v_q + 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      run_q <= 1'b0;
      h_q <= '0;
      v_q <= '0;
    end else begin
      run_q <= 1'b1;
      h_q <= h_d;
      v_q <= v_d;
    end
  end
  assign h_o = h_q;
  assign v_o = v_q;
  assign run_o = run_q;
  assign active_o = h_q < HW'(H_ACTIVE) && v_q < VW'(V_ACTIVE);
  assign hs_o = h_q >= HW'(H_ACTIVE + H_FP) && h_q < HW'(H_ACTIVE + H_FP + H_SYNC);
  assign vs_o = v_q >= VW'(V_ACTIVE + V_FP) && v_q < VW'(V_ACTIVE + V_FP + V_SYNC);
  assign origin_o = run_q && h_q == '0 && v_q == '0;
endmodule

// File: rtl/vga_pattern_ctrl.sv
// vga_pattern_ctrl: programmable VGA timing generator with a four-mode test-pattern engine.
// Mode and solid colour are latched at pixel (0,0) so a frame never mixes patterns.
module vga_pattern_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int COLOR_W = 8,
  parameter int CHECK_LOG2 = 5,
  localparam int XW = clog2w(H_ACTIVE),
  localparam int YW = clog2w(V_ACTIVE)
) (
  input  logic                 iVGA_CLK,
  input  logic                 iRST_n,
  input  logic [1:0]           iMODE,
  input  logic [3*COLOR_W-1:0] iSOLID_RGB,
  output logic                 oHS,
  output logic                 oVS,
  output logic                 oBLANK_n,
  output logic [XW-1:0]        oX,
  output logic [YW-1:0]        oY,
  output logic                 oFRAME_START,
  output logic [7:0]           oFRAME_CNT,
  output logic [COLOR_W-1:0]   r_data,
  output logic [COLOR_W-1:0]   g_data,
  output logic [COLOR_W-1:0]   b_data
);
  localparam int HW = clog2w(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = clog2w(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW = clog2w(BAR_W);
  if (H_ACTIVE < 8 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_ACTIVE < 1 || V_FP < 1 ||
      V_SYNC < 1 || V_BP < 1 || COLOR_W < 1 || CHECK_LOG2 < 0) begin : g_bad_params
    $fatal(1, "vga_pattern_ctrl: illegal parameter set");
  end
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic run, h_last, active, hs, vs, origin;
  vga_sync_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_cnt (
    .clk_i(iVGA_CLK),
    .rst_ni(iRST_n),
    .h_o(h),
    .v_o(v),
    .run_o(run),
    .h_last_o(h_last),
    .active_o(active),
    .hs_o(hs),
    .vs_o(vs),
    .origin_o(origin)
  );
  mode_e mode_q, mode_c;
  logic [3*COLOR_W-1:0] solid_q, solid_c, rgb_q, rgb_c;
  logic [7:0] fcnt_q, fcnt_d;
  logic [2:0] bidx_q, bidx_d, bar_c;
  logic [BW-1:0] bpix_q, bpix_d;
  logic [XW-1:0] x_q, x_c;
  logic [YW-1:0] y_q, y_c;
  logic seen_q, hs_q, vs_q, blank_q, fs_q, chk_c, bar_end;
  always_comb begin
    mode_c = origin ? mode_e'(iMODE) : mode_q;
    solid_c = origin ? iSOLID_RGB : solid_q;
    fcnt_d = origin && seen_q ? fcnt_q + 8'd1 : fcnt_q;
    bar_end = bpix_q == BW'(BAR_W - 1);
    bpix_d = h_last || bar_end ? '0 : bpix_q + 1'b1;
    bidx_d = h_last ? 3'd0 : bar_end && bidx_q != 3'd7 ? bidx_q + 3'd1 : bidx_q;
    x_c = active ? XW'(h) : '0;
    y_c = active ? YW'(v) : '0;
    chk_c = 1'((32'(x_c) ^ 32'(y_c)) >> CHECK_LOG2);
    bar_c = BAR_LUT[bidx_q];
    rgb_c = !active ? '0 :
            mode_c == MODE_SOLID ? solid_c :
            mode_c == MODE_BARS ? {{COLOR_W{bar_c[2]}}, {COLOR_W{bar_c[1]}}, {COLOR_W{bar_c[0]}}} :
            mode_c == MODE_CHECK ? {(3*COLOR_W){~chk_c}} :
            {COLOR_W'(x_c), COLOR_W'(y_c), COLOR_W'(fcnt_d)};
  end
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      mode_q <= MODE_SOLID;
      solid_q <= '0;
      seen_q <= 1'b0;
      fcnt_q <= '0;
      bidx_q <= '0;
      bpix_q <= '0;
      hs_q <= !HS_POL;
      vs_q <= !VS_POL;
      blank_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      fs_q <= 1'b0;
      rgb_q <= '0;
    end else if (run) begin
      mode_q <= mode_c;
      solid_q <= solid_c;
      seen_q <= seen_q | origin;
      fcnt_q <= fcnt_d;
      bidx_q <= bidx_d;
      bpix_q <= bpix_d;
      hs_q <= hs ? HS_POL : !HS_POL;
      vs_q <= vs ? VS_POL : !VS_POL;
      blank_q <= active;
      x_q <= x_c;
      y_q <= y_c;
      fs_q <= origin;
      rgb_q <= rgb_c;
    end
  end
  assign oHS = hs_q;
  assign oVS = vs_q;
  assign oBLANK_n = blank_q;
  assign oX = x_q;
  assign oY = y_q;
  assign oFRAME_START = fs_q;
  assign oFRAME_CNT = fcnt_q;
  assign {r_data, g_data, b_data} = rgb_q;
endmodule

// File: tb/tb_vga_pattern_ctrl.sv
// tb_vga_pattern_ctrl: two instances (mid-size active-low, tiny active-high) checked against
// a raster-arithmetic reference model every cycle, plus directed sequences and a bar table.
module tb_vga_pattern_ctrl;
  typedef struct packed {
    logic hs, vs, bl, fs;
    logic [31:0] x, y, fc, r, g, b;
  } out_t;
  typedef struct {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
    bit hpol, vpol;
    int cw, cl;
  } cfg_t;
  typedef struct {
    int h;
    bit bl;
    bit hs;
    logic [11:0] rgb;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [1:0] mode_a, mode_b;
  logic [23:0] solid_a;
  logic [11:0] solid_b;
  logic hs_a, vs_a, bl_a, fs_a, hs_b, vs_b, bl_b, fs_b;
  logic [6:0] x_a;
  logic [5:0] y_a;
  logic [2:0] x_b;
  logic [1:0] y_b;
  logic [7:0] fc_a, fc_b, r_a, g_a, b_a;
  logic [3:0] r_b, g_b, b_b;

  vga_pattern_ctrl #(
    .H_ACTIVE(68), .H_FP(4), .H_SYNC(8), .H_BP(4), .V_ACTIVE(40), .V_FP(2), .V_SYNC(3), .V_BP(3),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(8), .CHECK_LOG2(3)
  ) u_a (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iMODE(mode_a), .iSOLID_RGB(solid_a),
    .oHS(hs_a), .oVS(vs_a), .oBLANK_n(bl_a), .oX(x_a), .oY(y_a),
    .oFRAME_START(fs_a), .oFRAME_CNT(fc_a), .r_data(r_a), .g_data(g_a), .b_data(b_a)
  );

  vga_pattern_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(4), .CHECK_LOG2(1)
  ) u_b (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iMODE(mode_b), .iSOLID_RGB(solid_b),
    .oHS(hs_b), .oVS(vs_b), .oBLANK_n(bl_b), .oX(x_b), .oY(y_b),
    .oFRAME_START(fs_b), .oFRAME_CNT(fc_b), .r_data(r_b), .g_data(g_b), .b_data(b_b)
  );

  int n_chk = 0, n_fail = 0;
  cfg_t ca, cb;
  int ft_a, ft_b, k_a, k_b, ml_a, ml_b, sl_a, sl_b, cyc, last_fs_a;
  bit armed = 1'b0;
  out_t e_a, e_b;
  vec_t tbl_b[14];

  function automatic int ftot(input cfg_t c);
    return (c.ha + c.hfp + c.hsw + c.hbp) * (c.va + c.vfp + c.vsw + c.vbp);
  endfunction

  // Expected pins at the k-th edge after reset: position follows from plain raster arithmetic.
  function automatic out_t model(input cfg_t c, input int k, input int ml, input int sl);
    out_t o;
    int ht, vt, s, h, v, mx, bar, cbits;
    int lut[8] = '{7, 6, 3, 2, 5, 4, 1, 0};
    ht = c.ha + c.hfp + c.hsw + c.hbp;
    vt = c.va + c.vfp + c.vsw + c.vbp;
    o = '0;
    o.hs = !c.hpol;
    o.vs = !c.vpol;
    if (k < 2) return o;
    s = k - 2;
    h = s % ht;
    v = (s / ht) % vt;
    o.fc = (s / (ht * vt)) % 256;
    o.fs = h == 0 && v == 0;
    o.hs = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsw) ? c.hpol : !c.hpol;
    o.vs = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vsw) ? c.vpol : !c.vpol;
    o.bl = h < c.ha && v < c.va;
    if (!o.bl) return o;
    o.x = h;
    o.y = v;
    mx = (1 << c.cw) - 1;
    case (ml)
      0: begin
        o.r = (sl >> (2 * c.cw)) & mx;
        o.g = (sl >> c.cw) & mx;
        o.b = sl & mx;
      end
      1: begin
        bar = h / (c.ha / 8);
        if (bar > 7) bar = 7;
        cbits = lut[bar];
        o.r = cbits[2] ? mx : 0;
        o.g = cbits[1] ? mx : 0;
        o.b = cbits[0] ? mx : 0;
      end
      2: begin
        o.r = (((h >> c.cl) ^ (v >> c.cl)) & 1) != 0 ? 0 : mx;
        o.g = o.r;
        o.b = o.r;
      end
      default: begin
        o.r = h & mx;
        o.g = v & mx;
        o.b = o.fc & mx;
      end
    endcase
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp(input string name, input out_t a, input out_t e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got hs%0b vs%0b bl%0b fs%0b x%0d y%0d fc%0d rgb %0h/%0h/%0h expected hs%0b vs%0b bl%0b fs%0b x%0d y%0d fc%0d rgb %0h/%0h/%0h",
               name, cyc, a.hs, a.vs, a.bl, a.fs, a.x, a.y, a.fc, a.r, a.g, a.b,
               e.hs, e.vs, e.bl, e.fs, e.x, e.y, e.fc, e.r, e.g, e.b);
    end
  endtask

  // One clock: advance the reference at the edge, compare both instances on the falling edge.
  task automatic tick();
    out_t act;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      armed = 1'b1;
      k_a = 0;
      k_b = 0;
      last_fs_a = -1;
    end else begin
      k_a++;
      k_b++;
    end
    if (k_a >= 2 && (k_a - 2) % ft_a == 0) begin ml_a = int'(mode_a); sl_a = int'(solid_a); end
    if (k_b >= 2 && (k_b - 2) % ft_b == 0) begin ml_b = int'(mode_b); sl_b = int'(solid_b); end
    e_a = model(ca, k_a, ml_a, sl_a);
    e_b = model(cb, k_b, ml_b, sl_b);
    @(negedge clk);
    if (armed) begin
      act = {hs_a, vs_a, bl_a, fs_a, 32'(x_a), 32'(y_a), 32'(fc_a), 32'(r_a), 32'(g_a), 32'(b_a)};
      cmp("model_a", act, e_a);
      act = {hs_b, vs_b, bl_b, fs_b, 32'(x_b), 32'(y_b), 32'(fc_b), 32'(r_b), 32'(g_b), 32'(b_b)};
      cmp("model_b", act, e_b);
      if (fs_a) begin
        if (last_fs_a >= 0) chk("frame_period_a", 64'(cyc - last_fs_a), 64'(ft_a));
        last_fs_a = cyc;
      end
    end
  endtask

  task automatic wait_fs_a(input int lim, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!fs_a && n < lim);
    if (!fs_a) n = -1;
  endtask

  initial begin
    int n;
    bit found;
    ca = '{ha: 68, hfp: 4, hsw: 8, hbp: 4, va: 40, vfp: 2, vsw: 3, vbp: 3, hpol: 1'b0, vpol: 1'b0, cw: 8, cl: 3};
    cb = '{ha: 8, hfp: 2, hsw: 3, hbp: 1, va: 4, vfp: 1, vsw: 1, vbp: 1, hpol: 1'b1, vpol: 1'b1, cw: 4, cl: 1};
    ft_a = ftot(ca);
    ft_b = ftot(cb);
    tbl_b[0] = '{0, 1'b1, 1'b0, 12'hFFF};
    tbl_b[1] = '{1, 1'b1, 1'b0, 12'hFF0};
    tbl_b[2] = '{2, 1'b1, 1'b0, 12'h0FF};
    tbl_b[3] = '{3, 1'b1, 1'b0, 12'h0F0};
    tbl_b[4] = '{4, 1'b1, 1'b0, 12'hF0F};
    tbl_b[5] = '{5, 1'b1, 1'b0, 12'hF00};
    tbl_b[6] = '{6, 1'b1, 1'b0, 12'h00F};
    tbl_b[7] = '{7, 1'b1, 1'b0, 12'h000};
    tbl_b[8] = '{8, 1'b0, 1'b0, 12'h000};
    tbl_b[9] = '{9, 1'b0, 1'b0, 12'h000};
    tbl_b[10] = '{10, 1'b0, 1'b1, 12'h000};
    tbl_b[11] = '{11, 1'b0, 1'b1, 12'h000};
    tbl_b[12] = '{12, 1'b0, 1'b1, 12'h000};
    tbl_b[13] = '{13, 1'b0, 1'b0, 12'h000};
    cyc = 0; k_a = 0; k_b = 0; ml_a = 0; ml_b = 0; sl_a = 0; sl_b = 0; last_fs_a = -1;
    rst_n = 1'b0;
    mode_a = 2'd3;
    mode_b = 2'd1;
    solid_a = 24'h0;
    solid_b = 12'h0;
    repeat (5) tick();
    chk("reset_a", {hs_a, vs_a, bl_a, fs_a, fc_a, x_a, y_a, r_a, g_a, b_a}, {4'b1100, 8'd0, 13'd0, 24'd0});
    chk("reset_b", {hs_b, vs_b, bl_b, fs_b, fc_b, x_b, y_b, r_b, g_b, b_b}, {4'b0000, 8'd0, 5'd0, 12'd0});
    // first pulse on the 2nd edge after release, then one per frame with 0,1,2
    rst_n = 1'b1;
    wait_fs_a(10, n);
    chk("first_fs_edge", 64'(n), 64'd2);
    chk("first_fc", 64'(fc_a), 64'd0);
    wait_fs_a(ft_a + 10, n);
    chk("fs_period_1", 64'(n), 64'(ft_a));
    chk("fc_1", 64'(fc_a), 64'd1);
    wait_fs_a(ft_a + 10, n);
    chk("fs_period_2", 64'(n), 64'(ft_a));
    chk("fc_2", 64'(fc_a), 64'd2);
    // colour-bar line on the tiny instance
    found = 1'b0;
    for (int i = 0; i < 3 * ft_b && !found; i++) begin
      tick();
      found = fs_b;
    end
    chk("bars_sync", 64'(found), 64'd1);
    for (int i = 0; i < 14; i++) begin
      if (i > 0) tick();
      chk($sformatf("bars_h%0d", tbl_b[i].h), {bl_b, hs_b, r_b, g_b, b_b}, {tbl_b[i].bl, tbl_b[i].hs, tbl_b[i].rgb});
    end
    // mode switch mid-frame: current frame stays solid, next frame is checker
    mode_a = 2'd0;
    solid_a = 24'h123456;
    wait_fs_a(ft_a + 10, n);
    chk("solid_origin", {r_a, g_a, b_a}, 24'h123456);
    repeat (100) tick();
    mode_a = 2'd2;
    solid_a = 24'hABCDEF;
    repeat (10 * 84 + 5 - 100) tick();
    chk("solid_mid_xy", {x_a, y_a}, {7'd5, 6'd10});
    chk("solid_mid_rgb", {r_a, g_a, b_a}, 24'h123456);
    wait_fs_a(ft_a + 10, n);
    chk("switch_wait", 64'(n), 64'(ft_a - 845));
    chk("check_0_0", {r_a, g_a, b_a}, 24'hFFFFFF);
    repeat (8) tick();
    chk("check_8_0", {x_a, r_a, g_a, b_a}, {7'd8, 24'h000000});
    repeat (8) tick();
    chk("check_16_0", {x_a, r_a, g_a, b_a}, {7'd16, 24'hFFFFFF});
    // reset at line 20, pixel 30
    repeat (20 * 84 + 30 - 16) tick();
    chk("pre_reset_xy", {bl_a, x_a, y_a}, {1'b1, 7'd30, 6'd20});
    rst_n = 1'b0;
    tick();
    chk("midreset_a", {hs_a, vs_a, bl_a, fs_a, fc_a, x_a, y_a, r_a, g_a, b_a}, {4'b1100, 8'd0, 13'd0, 24'd0});
    rst_n = 1'b1;
    tick();
    chk("post_release_1", {fs_a, bl_a, fc_a}, 10'd0);
    tick();
    chk("post_release_2", {fs_a, bl_a, fc_a, x_a, y_a}, {2'b11, 8'd0, 13'd0});
    // randomized run: inputs change freely, only frame-start samples may take effect
    for (int i = 0; i < 28000; i++) begin
      if ($urandom_range(7) == 0) mode_a = 2'($urandom_range(3));
      if ($urandom_range(7) == 0) mode_b = 2'($urandom_range(3));
      solid_a = 24'($urandom);
      solid_b = 12'($urandom);
      tick();
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
